// File: rtl/hwag_tooth_scheduler.sv
// hwag_tooth_scheduler: tooth-synchronous scan of a CPU channel table
// that sets/clears one actuator output per channel on matching teeth.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   hwag_start      sync flag; low forces all outputs off and stops a scan
//   tooth_edge      one-cycle qualified tooth edge pulse
//   tooth_num       tooth count, valid with tooth_edge
//   cfg_we/addr/data  table write port (2i: set tooth, 2i+1: rst tooth + en)
//   ch_out          channel outputs
//   busy            high while scanning
//   scan_done       one-cycle pulse after the last channel is updated
//   overrun_if      one-cycle pulse when a tooth edge is dropped
module hwag_tooth_scheduler #(
  parameter int CH = 8,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hwag_start,
  input  logic          tooth_edge,
  input  logic [TW-1:0] tooth_num,
  input  logic          cfg_we,
  input  logic [7:0]    cfg_addr,
  input  logic [15:0]   cfg_data,
  output logic [CH-1:0] ch_out,
  output logic          busy,
  output logic          scan_done,
  output logic          overrun_if
);

  localparam int IW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] idx;
  logic [TW-1:0] latched;

  logic [TW-1:0] set_t [CH];
  logic [TW-1:0] rst_t [CH];
  logic [CH-1:0] en;

  logic [TW-1:0] cur_set;
  logic [TW-1:0] cur_rst;
  logic          cur_en;
  logic          last;
  logic          hit_rst;
  logic          hit_set;

  // Only the low TW bits and bit 15 are stored.
  logic cfg_unused;
  assign cfg_unused = ^cfg_data;

  always_comb begin
    cur_set = '0;
    cur_rst = '0;
    cur_en  = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (IW'(i) == idx) begin
        cur_set = set_t[i];
        cur_rst = rst_t[i];
        cur_en  = en[i];
      end
    end
  end

  assign last    = (idx == IW'(CH - 1));
  assign hit_rst = cur_en && (latched == cur_rst);
  assign hit_set = cur_en && (latched == cur_set);
  assign busy    = (state == SCAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      en <= '0;
      for (int i = 0; i < CH; i++) begin
        set_t[i] <= '0;
        rst_t[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < CH; i++) begin
        if (cfg_addr == 8'(2 * i)) begin
          set_t[i] <= cfg_data[TW-1:0];
        end
        if (cfg_addr == 8'(2 * i + 1)) begin
          rst_t[i] <= cfg_data[TW-1:0];
          en[i]    <= cfg_data[15];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      latched    <= '0;
      ch_out     <= '0;
      scan_done  <= 1'b0;
      overrun_if <= 1'b0;
    end else begin
      scan_done  <= 1'b0;
      overrun_if <= 1'b0;
      if (!hwag_start) begin
        state  <= IDLE;
        idx    <= '0;
        ch_out <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (tooth_edge) begin
              latched <= tooth_num;
              idx     <= '0;
              state   <= SCAN;
            end
          end
          SCAN: begin
            // reset tooth has priority over set tooth
            if (hit_rst) begin
              ch_out[idx] <= 1'b0;
            end else if (hit_set) begin
              ch_out[idx] <= 1'b1;
            end
            if (last) begin
              scan_done <= 1'b1;
              idx       <= '0;
              // an edge on the final step chains straight into a new scan
              if (tooth_edge) begin
                latched <= tooth_num;
              end else begin
                state <= IDLE;
              end
            end else begin
              idx <= idx + 1'b1;
              if (tooth_edge) begin
                overrun_if <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hwag_tooth_scheduler.sv
// tb_hwag_tooth_scheduler: directed and randomized bench with a
// time-based reference model of the tooth scheduler.
module tb_hwag_tooth_scheduler;

  localparam int CH = 8;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hwag_start = 1'b0;
  logic          tooth_edge = 1'b0;
  logic [TW-1:0] tooth_num = '0;
  logic          cfg_we = 1'b0;
  logic [7:0]    cfg_addr = '0;
  logic [15:0]   cfg_data = '0;
  logic [CH-1:0] ch_out;
  logic          busy;
  logic          scan_done;
  logic          overrun_if;

  int checks = 0;
  int errors = 0;

  hwag_tooth_scheduler #(.CH(CH), .TW(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .hwag_start (hwag_start),
    .tooth_edge (tooth_edge),
    .tooth_num  (tooth_num),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .ch_out     (ch_out),
    .busy       (busy),
    .scan_done  (scan_done),
    .overrun_if (overrun_if)
  );

  always #5 clk = ~clk;

  // Reference model: a scan is described by the cycle its edge was
  // sampled in; channel i is evaluated in cycle start+1+i.
  int            cyc = 0;
  int            sc_start = 0;
  bit            active = 0;
  logic [TW-1:0] sc_tooth = '0;
  logic [TW-1:0] m_set [CH];
  logic [TW-1:0] m_rst [CH];
  bit            m_en  [CH];
  logic [CH-1:0] m_ch = '0;
  bit            m_busy = 0;
  bit            m_done = 0;
  bit            m_ovr = 0;

  task automatic tick(input logic e, input logic [TW-1:0] num,
                      input logic hs, input logic we,
                      input logic [7:0] a, input logic [15:0] d);
    int i;
    tooth_edge = e;
    tooth_num  = num;
    hwag_start = hs;
    cfg_we     = we;
    cfg_addr   = a;
    cfg_data   = d;
    @(posedge clk);
    m_done = 0;
    m_ovr  = 0;
    if (rst) begin
      for (int k = 0; k < CH; k++) begin
        m_set[k] = '0;
        m_rst[k] = '0;
        m_en[k]  = 0;
      end
      active   = 0;
      sc_tooth = '0;
      m_ch     = '0;
    end else begin
      if (!hs) begin
        m_ch   = '0;
        active = 0;
      end else begin
        if (active) begin
          i = cyc - sc_start - 1;
          if (m_en[i] && sc_tooth == m_rst[i]) m_ch[i] = 1'b0;
          else if (m_en[i] && sc_tooth == m_set[i]) m_ch[i] = 1'b1;
          if (i == CH - 1) begin
            m_done = 1;
            active = 0;
          end else if (e) begin
            m_ovr = 1;
          end
        end
        if (e && !active) begin
          active   = 1;
          sc_start = cyc;
          sc_tooth = num;
        end
      end
      if (we && a < 8'(2 * CH)) begin
        if (a[0]) begin
          m_rst[a >> 1] = d[TW-1:0];
          m_en[a >> 1]  = d[15];
        end else begin
          m_set[a >> 1] = d[TW-1:0];
        end
      end
    end
    m_busy = active;
    cyc++;
    #1;
  endtask

  task automatic idle(input logic hs);
    tick(1'b0, '0, hs, 1'b0, 8'h00, 16'h0000);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    tick(1'b0, '0, hwag_start, 1'b1, a, d);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
    checks++;
    if (ch_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_ch_out got %h want 00", ch_out);
    end
    checks++;
    if (busy !== 1'b0 || scan_done !== 1'b0 || overrun_if !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got %b%b%b want 000", busy, scan_done,
               overrun_if);
    end
    wr(8'd0, 16'd5);
    wr(8'd1, 16'h8009);
  endtask

  task automatic test_set_reset;
    tick(1'b1, 8'd4, 1'b1, 1'b0, 8'h00, 16'h0000);
    for (int k = 1; k <= CH; k++) begin
      checks++;
      if (busy !== 1'b1 || scan_done !== 1'b0) begin
        errors++;
        $display("FAIL t4_busy k=%0d got b=%b d=%b want b=1 d=0", k, busy,
                 scan_done);
      end
      idle(1'b1);
    end
    checks++;
    if (scan_done !== 1'b1 || busy !== 1'b0 || ch_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL t4_done got d=%b b=%b ch0=%b want 1 0 0", scan_done,
               busy, ch_out[0]);
    end
    tick(1'b1, 8'd5, 1'b1, 1'b0, 8'h00, 16'h0000);
    checks++;
    if (ch_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL t5_early got %b want 0", ch_out[0]);
    end
    idle(1'b1);
    checks++;
    if (ch_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL t5_set got %b want 1", ch_out[0]);
    end
    for (int k = 0; k < CH; k++) idle(1'b1);
    tick(1'b1, 8'd9, 1'b1, 1'b0, 8'h00, 16'h0000);
    for (int k = 0; k < CH; k++) idle(1'b1);
    checks++;
    if (ch_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL t9_clear got %b want 0", ch_out[0]);
    end
  endtask

  task automatic test_reset_priority;
    wr(8'd6, 16'd7);
    wr(8'd7, 16'h8008);
    tick(1'b1, 8'd7, 1'b1, 1'b0, 8'h00, 16'h0000);
    for (int k = 0; k < CH; k++) idle(1'b1);
    checks++;
    if (ch_out[3] !== 1'b1) begin
      errors++;
      $display("FAIL ch3_pre got %b want 1", ch_out[3]);
    end
    wr(8'd7, 16'h8007);
    tick(1'b1, 8'd7, 1'b1, 1'b0, 8'h00, 16'h0000);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    checks++;
    if (ch_out[3] !== 1'b1) begin
      errors++;
      $display("FAIL ch3_t4 got %b want 1", ch_out[3]);
    end
    idle(1'b1);
    checks++;
    if (ch_out[3] !== 1'b0) begin
      errors++;
      $display("FAIL ch3_rst_prio got %b want 0", ch_out[3]);
    end
    for (int k = 0; k < CH; k++) idle(1'b1);
  endtask

  task automatic test_overrun;
    tick(1'b1, 8'd5, 1'b1, 1'b0, 8'h00, 16'h0000);
    for (int k = 1; k <= CH; k++) begin
      checks++;
      if (overrun_if !== (k == 4) || scan_done !== 1'b0) begin
        errors++;
        $display("FAIL ovr k=%0d got o=%b d=%b want o=%b d=0", k,
                 overrun_if, scan_done, (k == 4));
      end
      if (k == 3) tick(1'b1, 8'd9, 1'b1, 1'b0, 8'h00, 16'h0000);
      else idle(1'b1);
    end
    checks++;
    if (scan_done !== 1'b1 || busy !== 1'b0 || ch_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_end got d=%b b=%b ch0=%b want 1 0 1", scan_done,
               busy, ch_out[0]);
    end
    idle(1'b1);
    checks++;
    if (scan_done !== 1'b0) begin
      errors++;
      $display("FAIL ovr_done2 got %b want 0", scan_done);
    end
  endtask

  task automatic test_back_to_back;
    tick(1'b1, 8'd9, 1'b1, 1'b0, 8'h00, 16'h0000);
    for (int k = 1; k <= 2 * CH; k++) begin
      checks++;
      if (busy !== 1'b1 || overrun_if !== 1'b0 ||
          scan_done !== (k == CH + 1)) begin
        errors++;
        $display("FAIL b2b k=%0d got b=%b o=%b d=%b", k, busy, overrun_if,
                 scan_done);
      end
      if (k == 2) begin
        checks++;
        if (ch_out[0] !== 1'b0) begin
          errors++;
          $display("FAIL b2b_clr got %b want 0", ch_out[0]);
        end
      end
      if (k == CH) tick(1'b1, 8'd5, 1'b1, 1'b0, 8'h00, 16'h0000);
      else idle(1'b1);
    end
    checks++;
    if (scan_done !== 1'b1 || busy !== 1'b0 || ch_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end got d=%b b=%b ch0=%b want 1 0 1", scan_done,
               busy, ch_out[0]);
    end
    idle(1'b1);
  endtask

  task automatic test_start_drop;
    tick(1'b1, 8'd5, 1'b1, 1'b0, 8'h00, 16'h0000);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    checks++;
    if (ch_out !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop got ch=%h b=%b want 00 0", ch_out, busy);
    end
    for (int k = 0; k < CH; k++) begin
      checks++;
      if (scan_done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL drop_quiet k=%0d got d=%b b=%b", k, scan_done, busy);
      end
      idle(1'b0);
    end
    tick(1'b1, 8'd5, 1'b0, 1'b0, 8'h00, 16'h0000);
    checks++;
    if (busy !== 1'b0 || overrun_if !== 1'b0) begin
      errors++;
      $display("FAIL drop_edge got b=%b o=%b want 0 0", busy, overrun_if);
    end
    tick(1'b1, 8'd5, 1'b1, 1'b0, 8'h00, 16'h0000);
    for (int k = 0; k < CH; k++) idle(1'b1);
    checks++;
    if (ch_out !== 8'h01 || scan_done !== 1'b1) begin
      errors++;
      $display("FAIL restart got ch=%h d=%b want 01 1", ch_out, scan_done);
    end
  endtask

  task automatic test_random;
    logic          e;
    logic          hs;
    logic          we;
    logic [7:0]    a;
    logic [15:0]   d;
    logic [TW-1:0] num;
    for (int n = 0; n < 3000; n++) begin
      e   = ($urandom % 4) == 0;
      hs  = ($urandom % 40) != 0;
      we  = ($urandom % 5) == 0;
      a   = 8'($urandom_range(0, 19));
      d   = {1'($urandom % 4 != 0), 7'd0, 8'($urandom_range(0, 7))};
      num = TW'($urandom_range(0, 7));
      rst = ($urandom % 400) == 0;
      tick(e, num, hs, we, a, d);
      rst = 1'b0;
      checks++;
      if (ch_out !== m_ch) begin
        errors++;
        $display("FAIL rnd_ch n=%0d got %h want %h", n, ch_out, m_ch);
      end
      checks++;
      if (busy !== m_busy) begin
        errors++;
        $display("FAIL rnd_busy n=%0d got %b want %b", n, busy, m_busy);
      end
      checks++;
      if (scan_done !== m_done) begin
        errors++;
        $display("FAIL rnd_done n=%0d got %b want %b", n, scan_done, m_done);
      end
      checks++;
      if (overrun_if !== m_ovr) begin
        errors++;
        $display("FAIL rnd_ovr n=%0d got %b want %b", n, overrun_if, m_ovr);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_set_reset();
    test_reset_priority();
    test_overrun();
    test_back_to_back();
    test_start_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hwag_tooth_scheduler.md
Name: hwag_tooth_scheduler

Overview:
- Tooth-synchronous output scheduler for the HWAG angle datapath.
- After synchronisation (hwag_start high), each qualified tooth edge latches the current tooth number.
- The block then scans a CPU-programmed channel table, one channel per clock, and sets or clears one output per channel on matching set/reset teeth.
- It sits between the tooth counter/start trigger and the actuator outputs, and raises a one-cycle overrun flag for the interrupt flag register.

Parameters:
- CH, 8, number of channels (1..64).
- TW, 8, tooth number width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hwag_start  in  1  synchronised flag; low forces all outputs off
- tooth_edge  in  1  one-cycle pulse per qualified tooth edge
- tooth_num  in  TW  current tooth count, valid in the tooth_edge cycle
- cfg_we  in  1  table write strobe
- cfg_addr  in  8  table address
- cfg_data  in  16  table write data
- ch_out  out  CH  channel outputs
- busy  out  1  high while scanning
- scan_done  out  1  one-cycle pulse after the last channel is updated
- overrun_if  out  1  one-cycle pulse when a tooth edge is dropped

Behaviour:
- Reset (rst=1 at a clock edge):
  - ch_out=0, busy=0, scan_done=0, overrun_if=0.
  - FSM=IDLE, scan index=0, latched tooth=0.
  - All table entries cleared: set=0, reset=0, enable=0.
  - Reset mid-scan aborts the scan with no further output updates.
- Table:
  - Entry i holds set_tooth[TW-1:0], rst_tooth[TW-1:0] and en.
  - Write to addr 2i: set_tooth=cfg_data[TW-1:0].
  - Write to addr 2i+1: rst_tooth=cfg_data[TW-1:0], en=cfg_data[15].
  - Addresses >= 2*CH are ignored.
  - A write lands at the clock edge. A scan step in the same cycle uses the pre-write value.
- FSM states: IDLE and SCAN.
- IDLE:
  - tooth_edge & hwag_start latches tooth_num and moves to SCAN with idx=0.
  - tooth_edge while hwag_start=0 is ignored, with no overrun.
- SCAN (busy=1), per cycle for channel idx:
  - If en & latched==rst_tooth: ch_out[idx]<=0.
  - Else if en & latched==set_tooth: ch_out[idx]<=1.
  - Reset wins when both match. en=0 leaves ch_out[idx] unchanged.
  - idx increments each cycle. Only channel idx changes per cycle.
  - At idx==CH-1, scan_done pulses in the following cycle and the FSM returns to IDLE.
- Timing: edge sampled in cycle T.
  - busy is high in cycles T+1..T+CH.
  - ch_out[i] is updated and visible from cycle T+2+i.
  - scan_done is high in cycle T+CH+1.
- Edge during SCAN:
  - If idx<CH-1: the edge is dropped, overrun_if pulses in the next cycle, and the scan continues.
  - If idx==CH-1: the edge is accepted, the new tooth is latched, the FSM goes directly to SCAN idx=0, busy stays high, and scan_done still pulses.
- hwag_start low in any cycle:
  - Next edge: ch_out=0, FSM=IDLE, idx=0, busy=0.
  - No scan_done or overrun_if pulse results from it.
  - The table is preserved.
- Tooth match is an exact TW-bit compare. There is no wrap arithmetic, so tooth 0 is an ordinary value.

Test Plan:
- Reset with CH=8: after rst, ch_out=0x00, busy=0. Write addr 0 = 5 and addr 1 = 0x8009 -> entry0 set=5, rst=9, en=1.
- With that entry, hwag_start=1, edges with tooth_num 4, 5, 9:
  - Tooth 4: ch_out[0] stays 0.
  - Tooth 5 (edge in cycle T): ch_out[0]=1 from T+2.
  - Tooth 9: ch_out[0]=0.
  - busy is high for 8 cycles per edge and scan_done pulses at T+9.
- Channel 3 set=rst=7, en=1, and ch_out[3] previously 1. Edge at tooth 7 -> ch_out[3]=0 from T+5 (reset priority).
- Edge at T, second edge at T+3 -> overrun_if=1 at T+4, scan_done only at T+9, and only the first tooth is applied.
- Edge at T, second edge at T+8 (idx=7) -> no overrun, busy continuous T+1..T+16, scan_done pulses at T+9 and T+17.
- Mid-scan hwag_start=0 at T+4 -> ch_out=0x00 and busy=0 from T+5, no scan_done. The table is retained: the same tooth after restart gives the same outputs.
